// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                  |
// | Description : Instruction fetch unit with in-order response queue,         |
// |               slot reservation, redirect flush and halt.                   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module fetch_queue #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                INC      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [DATA_W-1:0]        imem_rdata,
    output logic                     dec_valid,
    output logic [DATA_W-1:0]        dec_instr,
    output logic [ADDR_W-1:0]        dec_pc,
    output logic [ADDR_W-1:0]        dec_pc2,
    input  logic                     dec_ready,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     halt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                  c_PTR_W = $clog2(DEPTH);
    localparam int                  c_CNT_W = c_PTR_W + 1;
    localparam logic [ADDR_W-1:0]   c_INC   = ADDR_W'(INC);
    localparam logic [c_CNT_W:0]    c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  r_fpc;
    logic [ADDR_W-1:0]  r_rpc;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_out_cnt;
    logic [c_CNT_W-1:0] r_drop_cnt;
    logic [DATA_W-1:0]  r_mem_instr [DEPTH];
    logic [ADDR_W-1:0]  r_mem_pc    [DEPTH];

    logic [c_CNT_W:0]   w_occ;
    logic               w_grant;
    logic               w_rsp;
    logic               w_push;
    logic               w_pop;

    // Queued plus in-flight entries never exceed DEPTH, so every response has a slot.
    assign w_occ     = {1'b0, r_count} + {1'b0, r_out_cnt};
    assign imem_req  = rst & ~halt & ~redirect & (w_occ < c_DEPTH);
    assign imem_addr = r_fpc;
    assign w_grant   = imem_req & imem_gnt;
    assign w_rsp     = imem_rvalid & (r_out_cnt != '0);
    assign w_push    = w_rsp & (r_drop_cnt == '0) & ~redirect;

    assign dec_valid = rst & (r_count != '0);
    assign w_pop     = dec_valid & dec_ready & ~redirect;
    assign dec_instr = r_mem_instr[r_rd_ptr];
    assign dec_pc    = r_mem_pc[r_rd_ptr];
    assign dec_pc2   = dec_pc + c_INC;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fpc      <= RESET_PC;
            r_rpc      <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
        end else if (redirect) begin
            // Everything still in flight becomes stale; a response landing now is consumed.
            r_fpc      <= redirect_pc;
            r_rpc      <= redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_out_cnt  <= r_out_cnt - c_CNT_W'(w_rsp);
            r_drop_cnt <= r_out_cnt - c_CNT_W'(w_rsp);
        end else begin
            if (w_grant) begin
                r_fpc <= r_fpc + c_INC;
            end
            r_out_cnt <= r_out_cnt + c_CNT_W'(w_grant) - c_CNT_W'(w_rsp);
            if (w_rsp && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - c_CNT_W'(1);
            end
            if (w_push) begin
                r_rpc    <= r_rpc + c_INC;
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem_instr[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]    <= r_rpc;
        end
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DATA_W, default 16, instruction width.
REQ-002 Parameter ADDR_W, default 16, PC/address width.
REQ-003 Parameter DEPTH, default 4, instruction queue entries; power of 2, >= 2.
REQ-004 Parameter RESET_PC, default 0, PC loaded at reset.
REQ-005 Parameter INC, default 2, PC increment per instruction.
REQ-006 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address (current fetch PC).
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  DATA_W  response instruction.
- dec_valid  out  1  queue head valid.
- dec_instr  out  DATA_W  head instruction.
- dec_pc  out  ADDR_W  head PC.
- dec_pc2  out  ADDR_W  head PC + INC.
- dec_ready  in  1  decode consumes head.
- redirect  in  1  branch/jump redirect.
- redirect_pc  in  ADDR_W  redirect target.
- halt  in  1  stop issuing new fetches.
- count  out  clog2(DEPTH)+1  queue occupancy.

Function
REQ-007 State: fetch PC (fpc), response PC (rpc), queue of DEPTH {instr, pc} entries with rd/wr pointers, outstanding counter (out_cnt), drop counter (drop_cnt); counters are clog2(DEPTH)+1 bits.
REQ-008 imem_req SHALL be 1 iff rst high, !halt, !redirect, and count + out_cnt < DEPTH; imem_addr SHALL equal fpc at all times.
REQ-009 On imem_req & imem_gnt: fpc <= fpc + INC, modulo 2^ADDR_W (wrap, no carry out); out_cnt increments.
REQ-010 On imem_rvalid with drop_cnt == 0: push {imem_rdata, rpc} at tail, rpc <= rpc + INC (wrap), out_cnt decrements.
REQ-011 On imem_rvalid with drop_cnt != 0: discard data, drop_cnt and out_cnt decrement, rpc unchanged.
REQ-012 imem_rvalid with out_cnt == 0 SHALL be ignored (no state change).
REQ-013 dec_valid = (count != 0); dec_instr/dec_pc from head; dec_pc2 = dec_pc + INC (wrap), combinational.
REQ-014 Pop on dec_valid & dec_ready; simultaneous push and pop SHALL leave count unchanged, both pointers advancing.
REQ-015 Queue SHALL never overflow: REQ-008 reservation guarantees a slot for every in-flight response.
REQ-016 Redirect (takes priority over all other updates except reset): fpc <= redirect_pc, rpc <= redirect_pc, queue flushed (count 0, pointers equal), pop that cycle suppressed, drop_cnt <= out_cnt minus any response consumed that cycle; out_cnt likewise updated.
REQ-017 Response arriving in the redirect cycle SHALL be discarded, never enqueued.
REQ-018 First fetch after redirect SHALL issue no earlier than the following cycle, at redirect_pc.
REQ-019 Halt SHALL block only new requests; in-flight responses are still accepted and queue drains normally; redirect while halted updates fpc/rpc and flushes.
REQ-020 Pointers wrap modulo DEPTH.

Reset
REQ-021 With rst low at a rising edge: fpc = rpc = RESET_PC, count = out_cnt = drop_cnt = 0, pointers 0.
REQ-022 While rst is low: imem_req = 0, dec_valid = 0, imem_addr = RESET_PC after first edge; inputs ignored.
REQ-023 Reset mid-operation SHALL abandon in-flight responses; responses arriving after reset release with out_cnt == 0 are ignored per REQ-012.

Verification
REQ-024 Reset, gnt=1, rvalid 1 cycle after each grant, dec_ready=1 -> dec_pc sequence 0x0000, 0x0002, 0x0004..., dec_pc2 = dec_pc+2, one instruction per cycle steady state.
REQ-025 DEPTH=4, dec_ready=0, gnt/rvalid always -> exactly 4 grants, count reaches 4, imem_req stays 0; raise dec_ready one cycle -> one pop, one new request.
REQ-026 2 requests outstanding, redirect to 0x0100 -> both later responses dropped, queue empty, next imem_addr 0x0100, first enqueued dec_pc 0x0100.
REQ-027 fpc 0xFFFE, ADDR_W=16 -> next fetch address 0x0000; entry at 0xFFFE has dec_pc2 0x0000.
REQ-028 halt=1 with 3 outstanding -> no new requests, all 3 responses enqueued, drain to count 0; halt=0 -> fetch resumes at next sequential PC.
REQ-029 Push and pop same cycle at count 2 -> count stays 2, head order preserved.
